// File: rtl/fill_sequencer.sv
// fill_sequencer: latches one fill command, then strobes math/row/fill per row until all_finish or MAX_ROWS; first row_start 2+MATH_CYCLES cycles after accept.
// cmd_ready only in IDLE (cmd_valid ignored while busy); optional WAIT timeout with ERR state under FILL_SEQ_TIMEOUT_EN.
module fill_sequencer #(
  parameter int MATH_CYCLES    = 2,
  parameter int MAX_ROWS       = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_fill_type,
  input  logic [47:0] cmd_coordinates,
  input  logic [23:0] cmd_color_code,
  input  logic        cmd_layer_num,
  output logic        fill_type,
  output logic [47:0] coordinates,
  output logic [23:0] color_code,
  output logic        layer_num,
  output logic        math_start,
  output logic        row_start,
  output logic        fill_start,
  input  logic        fill_done,
  input  logic        all_finish,
  output logic        busy,
  output logic [11:0] row_count,
  output logic        done,
  output logic        error
);

  if (MATH_CYCLES < 1 || MATH_CYCLES > 15 || MAX_ROWS < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("fill_sequencer: parameter out of range");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MATH,
    ST_MWAIT,
    ST_ROW,
    ST_GAP,
    ST_FILL,
    ST_WAIT,
    ST_DONE
`ifdef FILL_SEQ_TIMEOUT_EN
    , ST_ERR
`endif
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [11:0] row_next;
  logic        at_ceiling;

  // Saturating row increment; the ceiling compares against the post-increment count.
  assign row_next   = (row_count == 12'hFFF) ? row_count : row_count + 12'd1;
  assign at_ceiling = (int'(row_next) == MAX_ROWS);

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign math_start = (state == ST_MATH);
  assign row_start  = (state == ST_ROW);
  assign fill_start = (state == ST_FILL);
  assign done       = (state == ST_DONE);

`ifdef FILL_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_timer;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      row_count   <= '0;
      fill_type   <= 1'b0;
      coordinates <= '0;
      color_code  <= '0;
      layer_num   <= 1'b0;
`ifdef FILL_SEQ_TIMEOUT_EN
      wait_timer  <= '0;
      error       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            fill_type   <= cmd_fill_type;
            coordinates <= cmd_coordinates;
            color_code  <= cmd_color_code;
            layer_num   <= cmd_layer_num;
            row_count   <= '0;
`ifdef FILL_SEQ_TIMEOUT_EN
            error       <= 1'b0;
`endif
            state       <= ST_MATH;
          end
        end
        ST_MATH: begin
          wait_cnt <= 4'(MATH_CYCLES);
          state    <= ST_MWAIT;
        end
        ST_MWAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_ROW;
        end
        ST_ROW:  state <= ST_GAP;
        ST_GAP:  state <= ST_FILL;
        ST_FILL: begin
`ifdef FILL_SEQ_TIMEOUT_EN
          wait_timer <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fill_done) begin
            row_count <= row_next;
            state     <= (all_finish || at_ceiling) ? ST_DONE : ST_ROW;
          end
`ifdef FILL_SEQ_TIMEOUT_EN
          else if (wait_timer == TIMEOUT_LAST) begin
            error <= 1'b1;
            state <= ST_ERR;
          end else begin
            wait_timer <= wait_timer + 16'd1;
          end
`endif
        end
`ifdef FILL_SEQ_TIMEOUT_EN
        ST_ERR:  state <= ST_DONE;
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_sequencer.sv
// Bench for fill_sequencer: per-cycle comparison against a timeline computed from the command's row response delays.
module tb_fill_sequencer;

  localparam int MC  = 2;
  localparam int MC4 = 3;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_fill_type, cmd_layer_num;
  logic [47:0] cmd_coordinates;
  logic [23:0] cmd_color_code;
  logic        fill_type, layer_num;
  logic [47:0] coordinates;
  logic [23:0] color_code;
  logic        math_start, row_start, fill_start, fill_done, all_finish;
  logic        busy, done, error;
  logic [11:0] row_count;

  logic        c4_cmd_valid, c4_cmd_ready, c4_fill_type, c4_layer_num;
  logic [47:0] c4_coordinates;
  logic [23:0] c4_color_code;
  logic        c4_math_start, c4_row_start, c4_fill_start, c4_fill_done, c4_all_finish;
  logic        c4_busy, c4_done, c4_error;
  logic [11:0] c4_row_count;

  int checks   = 0;
  int failures = 0;

  fill_sequencer #(.MATH_CYCLES(MC), .MAX_ROWS(1024), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill_type(cmd_fill_type), .cmd_coordinates(cmd_coordinates),
    .cmd_color_code(cmd_color_code), .cmd_layer_num(cmd_layer_num),
    .fill_type(fill_type), .coordinates(coordinates),
    .color_code(color_code), .layer_num(layer_num),
    .math_start(math_start), .row_start(row_start), .fill_start(fill_start),
    .fill_done(fill_done), .all_finish(all_finish),
    .busy(busy), .row_count(row_count), .done(done), .error(error)
  );

  fill_sequencer #(.MATH_CYCLES(MC4), .MAX_ROWS(4), .TIMEOUT_CYCLES(4096)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(c4_cmd_valid), .cmd_ready(c4_cmd_ready),
    .cmd_fill_type(1'b1), .cmd_coordinates(48'h123456789ABC),
    .cmd_color_code(24'h00FF00), .cmd_layer_num(1'b1),
    .fill_type(c4_fill_type), .coordinates(c4_coordinates),
    .color_code(c4_color_code), .layer_num(c4_layer_num),
    .math_start(c4_math_start), .row_start(c4_row_start), .fill_start(c4_fill_start),
    .fill_done(c4_fill_done), .all_finish(c4_all_finish),
    .busy(c4_busy), .row_count(c4_row_count), .done(c4_done), .error(c4_error)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // One command end to end. Expected behaviour comes from a timeline:
  // first row_start at 2+MC, fill_start 2 later, fill_done d later, next row_start 1 after that.
  task automatic run_command(input logic ft, input logic [47:0] co, input logic [23:0] cc,
                             input logic ly, input int n_rows, input int dmin, input int dmax,
                             input bit noisy, input bit hold,
                             output int n_rs, output int n_fs, output int n_done);
    int rs[$], fs[$], fd[$];
    int t, done_c, exp_rc;
    bit exp_rs, exp_fs, in_wait, is_fd;
    logic [5:0] obs, exp_v;
    n_rs = 0; n_fs = 0; n_done = 0;
    t = 2 + MC;
    for (int k = 0; k < n_rows; k++) begin
      rs.push_back(t);
      fs.push_back(t + 2);
      fd.push_back(t + 2 + int'($urandom_range(dmax, dmin)));
      t = fd[k] + 1;
    end
    done_c = fd[n_rows-1] + 1;

    cmd_fill_type = ft; cmd_coordinates = co; cmd_color_code = cc; cmd_layer_num = ly;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: cmd_ready=%b required 1", cmd_ready);
    end

    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      exp_rs = 0; exp_fs = 0; exp_rc = 0; in_wait = 0; is_fd = 0;
      foreach (rs[k]) begin
        if (rs[k] == c) exp_rs = 1;
        if (fs[k] == c) exp_fs = 1;
        if (fd[k] < c) exp_rc++;
        if (c > fs[k] && c < fd[k]) in_wait = 1;
        if (c == fd[k]) is_fd = 1;
      end
      obs   = {math_start, row_start, fill_start, done, busy, cmd_ready};
      exp_v = {c == 1, exp_rs, exp_fs, c == done_c, c <= done_c, c == done_c + 1};
      n_rs += int'(row_start); n_fs += int'(fill_start); n_done += int'(done);

      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL strobes cycle %0d: {math,row,fill,done,busy,ready}=%b required %b", c, obs, exp_v);
      end
      checks++;
      if (row_count !== 12'(exp_rc)) begin
        failures++;
        $display("FAIL row_count cycle %0d: got %0d required %0d", c, row_count, exp_rc);
      end
      checks++;
      if ({fill_type, coordinates, color_code, layer_num} !== {ft, co, cc, ly}) begin
        failures++;
        $display("FAIL latched cycle %0d: got %b/%h/%h/%b required %b/%h/%h/%b",
                 c, fill_type, coordinates, color_code, layer_num, ft, co, cc, ly);
      end
      checks++;
      if (error !== 1'b0) begin
        failures++;
        $display("FAIL error cycle %0d: got %b required 0", c, error);
      end

      cmd_valid = hold && (c <= done_c);
      if (hold) begin
        cmd_fill_type   = 1'($urandom);
        cmd_coordinates = {16'($urandom), $urandom};
        cmd_color_code  = 24'($urandom);
        cmd_layer_num   = 1'($urandom);
      end
      if (is_fd) begin
        fill_done  = 1'b1;
        all_finish = (c == fd[n_rows-1]);
      end else if (in_wait) begin
        fill_done  = 1'b0;
        all_finish = 1'($urandom);
      end else begin
        fill_done  = noisy ? 1'($urandom) : 1'b0;
        all_finish = 1'($urandom);
      end
    end
    cmd_valid = 1'b0; fill_done = 1'b0; all_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; fill_done = 1'b0; all_finish = 1'b0;
    cmd_fill_type = 1'b0; cmd_coordinates = '0; cmd_color_code = '0; cmd_layer_num = 1'b0;
    c4_cmd_valid = 1'b0; c4_fill_done = 1'b0; c4_all_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({math_start, row_start, fill_start, done, busy, cmd_ready, error} !== 7'b0000010 ||
        row_count !== 12'd0 || {fill_type, coordinates, color_code, layer_num} !== 74'd0) begin
      failures++;
      $display("FAIL reset_initial: strobes=%b row_count=%0d latched=%h required 0000010/0/0",
               {math_start, row_start, fill_start, done, busy, cmd_ready, error}, row_count,
               {fill_type, coordinates, color_code, layer_num});
    end

    // Complete one row, then reset while the second row sits in WAIT.
    cmd_fill_type = 1'b1; cmd_coordinates = 48'hABCDEF012345; cmd_color_code = 24'h55AA55;
    cmd_layer_num = 1'b1; cmd_valid = 1'b1;
    for (int c = 1; c <= 4 + MC + 5; c++) begin
      @(negedge clk);
      cmd_valid  = 1'b0;
      fill_done  = (c == 4 + MC + 1);
      all_finish = 1'b0;
    end
    fill_done = 1'b0;
    checks++;
    if ({math_start, row_start, fill_start, done, busy, cmd_ready} !== 6'b000010 || row_count !== 12'd1) begin
      failures++;
      $display("FAIL pre_reset_wait: strobes=%b row_count=%0d required 000010/1",
               {math_start, row_start, fill_start, done, busy, cmd_ready}, row_count);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      checks++;
      if ({math_start, row_start, fill_start, done, busy, cmd_ready, error} !== 7'b0000010 ||
          row_count !== 12'd0 || {fill_type, coordinates, color_code, layer_num} !== 74'd0) begin
        failures++;
        $display("FAIL reset_mid_wait[%0d]: strobes=%b row_count=%0d latched=%h required 0000010/0/0", i,
                 {math_start, row_start, fill_start, done, busy, cmd_ready, error}, row_count,
                 {fill_type, coordinates, color_code, layer_num});
      end
    end
  endtask

  task automatic test_single_row();
    int nr, nf, nd;
    run_command(1'b0, 48'h0C80C80CC0CC, 24'hFF0000, 1'b0, 1, 3, 3, 1'b0, 1'b0, nr, nf, nd);
    checks++;
    if (nr != 1 || nf != 1 || nd != 1 || row_count !== 12'd1) begin
      failures++;
      $display("FAIL single_row_counts: rs=%0d fs=%0d done=%0d row_count=%0d required 1/1/1/1", nr, nf, nd, row_count);
    end
  endtask

  task automatic test_multi_row();
    int nr, nf, nd;
    run_command(1'b1, 48'h001002003004, 24'h0000FF, 1'b1, 100, 1, 4, 1'b1, 1'b0, nr, nf, nd);
    checks++;
    if (nr != 100 || nf != 100 || nd != 1 || row_count !== 12'd100) begin
      failures++;
      $display("FAIL multi_row_counts: rs=%0d fs=%0d done=%0d row_count=%0d required 100/100/1/100", nr, nf, nd, row_count);
    end
  endtask

  task automatic test_back_to_back();
    int nr, nf, nd, rows;
    for (int i = 0; i < 4; i++) begin
      rows = int'($urandom_range(6, 1));
      run_command(1'($urandom), {16'($urandom), $urandom}, 24'($urandom), 1'($urandom),
                  rows, 1, 5, 1'b1, 1'b1, nr, nf, nd);
      checks++;
      if (nr != rows || nd != 1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: rs=%0d done=%0d required %0d/1", i, nr, nd, rows);
      end
    end
  endtask

  task automatic test_random();
    int nr, nf, nd, rows;
    for (int i = 0; i < 8; i++) begin
      repeat (int'($urandom_range(3, 0))) begin
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap[%0d]: ready=%b busy=%b required 1/0", i, cmd_ready, busy);
        end
      end
      rows = int'($urandom_range(12, 1));
      run_command(1'($urandom), {16'($urandom), $urandom}, 24'($urandom), 1'($urandom),
                  rows, 1, int'($urandom_range(6, 1)), 1'($urandom), 1'b0, nr, nf, nd);
      checks++;
      if (nf != rows || row_count !== 12'(rows)) begin
        failures++;
        $display("FAIL random_cmd[%0d]: fs=%0d row_count=%0d required %0d", i, nf, row_count, rows);
      end
    end
  endtask

  task automatic test_ceiling();
    int rs_cnt = 0, fd_cnt = 0, done_cnt = 0, pending = -1;
    int done_cyc = -1, fd_cyc = -1, first_fs = -1;
    c4_all_finish = 1'b0;
    c4_cmd_valid  = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      c4_cmd_valid = 1'b0;
      c4_fill_done = 1'b0;
      if (c4_row_start) rs_cnt++;
      if (c4_done) begin done_cnt++; done_cyc = c; end
      if (c4_fill_start) begin
        if (first_fs < 0) first_fs = c;
        pending = 2;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          c4_fill_done = 1'b1; fd_cnt++; fd_cyc = c; pending = -1;
        end
      end
    end
    c4_fill_done = 1'b0;
    checks++;
    if (rs_cnt != 4 || fd_cnt != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL ceiling_counts: rs=%0d fill_done=%0d done=%0d required 4/4/1", rs_cnt, fd_cnt, done_cnt);
    end
    checks++;
    if (done_cyc != fd_cyc + 1 || first_fs != 4 + MC4) begin
      failures++;
      $display("FAIL ceiling_timing: done@%0d first_fs@%0d required %0d/%0d", done_cyc, first_fs, fd_cyc + 1, 4 + MC4);
    end
    checks++;
    if (c4_row_count !== 12'd4 || c4_cmd_ready !== 1'b1 || c4_busy !== 1'b0) begin
      failures++;
      $display("FAIL ceiling_end: row_count=%0d ready=%b busy=%b required 4/1/0", c4_row_count, c4_cmd_ready, c4_busy);
    end
  endtask

`ifdef FILL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc = -1, done_cyc = -1, nr, nf, nd;
    int exp_err = 4 + MC + TO + 1;
    cmd_fill_type = 1'b0; cmd_coordinates = 48'h111222333444; cmd_color_code = 24'h123456;
    cmd_layer_num = 1'b0; cmd_valid = 1'b1;
    for (int c = 1; c <= exp_err + 6; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; fill_done = 1'b0;
      if (error === 1'b1 && err_cyc < 0) err_cyc = c;
      if (done === 1'b1) done_cyc = c;
    end
    checks++;
    if (err_cyc != exp_err || done_cyc != exp_err + 1) begin
      failures++;
      $display("FAIL timeout_timing: error@%0d done@%0d required %0d/%0d", err_cyc, done_cyc, exp_err, exp_err + 1);
    end
    checks++;
    if (error !== 1'b1 || cmd_ready !== 1'b1 || row_count !== 12'd0) begin
      failures++;
      $display("FAIL timeout_sticky: error=%b ready=%b row_count=%0d required 1/1/0", error, cmd_ready, row_count);
    end
    run_command(1'b1, 48'h0, 24'hFFFFFF, 1'b1, 2, 1, 3, 1'b0, 1'b0, nr, nf, nd);
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_multi_row();
    test_back_to_back();
    test_random();
    test_ceiling();
`ifdef FILL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fill_sequencer.md
# fill_sequencer

Command-level controller for the polygon fill datapath. It accepts one fill command at a time and latches its parameters. It then drives the fill block's math/row/fill strobe protocol row by row until the fill block reports completion or a row-count ceiling is reached. It sits between the GPU command decoder and the fill block, and holds all fill-block inputs stable for the whole operation.

## Interface
Parameters:
- MATH_CYCLES, 2, number of idle cycles after math_start before the first row_start (1..15)
- MAX_ROWS, 1024, row ceiling; a command stops after this many rows even if all_finish never arrives
- TIMEOUT_CYCLES, 4096, cycles allowed in WAIT per row before error (used only with FILL_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_fill_type  in  1  fill type
- cmd_coordinates  in  48  {x0,y0,x1,y1}, 12 bits each
- cmd_color_code  in  24  RGB 8:8:8
- cmd_layer_num  in  1  target layer
- fill_type  out  1  latched fill type to fill block
- coordinates  out  48  latched coordinates to fill block
- color_code  out  24  latched color to fill block
- layer_num  out  1  latched layer to fill block
- math_start  out  1  one-cycle strobe
- row_start  out  1  one-cycle strobe per row
- fill_start  out  1  one-cycle strobe per row
- fill_done  in  1  fill block finished current row
- all_finish  in  1  fill block has no more rows; sampled only with fill_done
- busy  out  1  high in every state except IDLE
- row_count  out  12  rows completed for current command
- done  out  1  one-cycle pulse at command end
- error  out  1  sticky; set on timeout, cleared on next command accept

## Operation
- Moore FSM. All strobes are decoded from the registered state.
- States: IDLE, MATH, MWAIT, ROW, GAP, FILL, WAIT, DONE, plus ERR with the macro.
- IDLE: cmd_ready=1. On cmd_valid: latch all cmd_* fields, clear row_count, clear error, go to MATH.
- MATH: math_start=1. Go to MWAIT and load the wait counter with MATH_CYCLES.
- MWAIT: decrement the counter. Go to ROW when it reaches 0.
- ROW: row_start=1, then GAP (strobe-free cycle), then FILL.
- FILL: fill_start=1, then WAIT.
- WAIT, on fill_done:
  - row_count increments (saturating at 4095).
  - If all_finish=1, or the new row_count equals MAX_ROWS, go to DONE.
  - Otherwise go to ROW.
- fill_done and all_finish are ignored in every state other than WAIT.
- DONE: done=1 for one cycle, then IDLE.
- cmd_valid is ignored while busy. Latched outputs change only on accept.
- Reset in any state: go to IDLE the same edge. All outputs are 0 except cmd_ready=1. Latched fields, row_count and error are all cleared.

## Timing
- Cycle numbering: accept handshake at edge 0.
  - math_start is high in cycle 1.
  - MWAIT occupies cycles 2..1+MATH_CYCLES.
  - row_start is high in cycle 2+MATH_CYCLES.
  - fill_start is high in cycle 4+MATH_CYCLES.
- fill_done in WAIT cycle t:
  - If the command continues, row_start is high in cycle t+1.
  - If the command ends, done is high in cycle t+1 and cmd_ready is high in cycle t+2.
- fill_done asserted in the same cycle as fill_start is not seen. The earliest honoured fill_done is the cycle after fill_start.
- Minimum row period is 4 cycles (ROW, GAP, FILL, WAIT).
- row_count updates on the edge leaving WAIT.

## Configuration
- FILL_SEQ_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without fill_done: go to ERR, set error, then DONE (done pulse) and IDLE.
- FILL_SEQ_TIMEOUT_EN undefined:
  - No counter and no ERR state; WAIT waits forever.
  - error is tied to 0.

## Test plan
- Reset: assert rst for 2 cycles mid-WAIT → cmd_ready=1, busy=0, row_count=0, all strobes 0 on the next cycle.
- Single row: accept command (coordinates 48'h0C80C80CC0CC, color 24'hFF0000, layer 0, MATH_CYCLES=2), then return fill_done+all_finish 3 cycles after fill_start.
  - math_start in cycle 1, row_start in cycle 4, fill_start in cycle 6.
  - done one cycle after fill_done; row_count=1.
  - Latched outputs equal the command values throughout.
- Multi-row: respond to 100 fill_start strobes, with all_finish on the 100th → exactly 100 row_start and 100 fill_start pulses, row_count=100, one done.
- Ceiling: MAX_ROWS=4, all_finish never asserted → done after the 4th fill_done, row_count=4, no 5th row_start.
- Protocol robustness:
  - cmd_valid held high while busy → no re-latch; a new command is accepted only in the cycle after DONE.
  - Spurious fill_done in MWAIT or GAP → ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=16): fill_done withheld → error=1 and a done pulse after 16 WAIT cycles; error clears on the next accept.
